// File: rtl/store_align_unit.sv
// Store alignment unit: turns a byte-addressed store of width 1/2/4/8 bytes
// into one or two bus-aligned write beats with byte-lane masks, and reports
// completion (or rejection) with a single-cycle done pulse.
module store_align_unit #(
  parameter int XLEN           = 64,
  parameter bit ALLOW_MISALIGN = 1'b1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  input  logic [2:0]        req_width,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [XLEN/8-1:0] mem_wmask,
  output logic              done,
  output logic              err
);

  localparam int BW = XLEN / 8;
  localparam int OW = $clog2(BW);
  // Wide enough to hold a byte count up to 2*BW.
  localparam int SW = $clog2(2 * BW) + 1;

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

  state_t state_reg, state_next;

  logic [XLEN-1:0]   addr_reg;
  logic [2*BW-1:0]   mask_reg;
  logic [2*XLEN-1:0] data_reg;
  logic              split_reg;
  logic              err_reg;

  logic [SW-1:0]     size;
  logic              illegal;
  logic [OW-1:0]     off;
  logic [2*BW-1:0]   base_mask;
  logic [2*BW-1:0]   mask_new;
  logic [2*XLEN-1:0] data_new;
  logic              split_new;
  logic              reject_new;
  logic              accept;

  // Width code to byte count; code 000 is the only illegal encoding.
  always_comb begin
    size    = '0;
    illegal = 1'b0;
    case (req_width)
      3'b001:         size = SW'(8);
      3'b010, 3'b101: size = SW'(4);
      3'b011, 3'b110: size = SW'(2);
      3'b100, 3'b111: size = SW'(1);
      default:        illegal = 1'b1;
    endcase
  end

  // Unshifted mask of 'size' ones, built bit by bit so any XLEN works.
  generate
    for (genvar gi = 0; gi < 2 * BW; gi++) begin : g_base_mask
      assign base_mask[gi] = (SW'(gi) < size);
    end
  endgenerate

  assign off        = req_addr[OW-1:0];
  assign mask_new   = base_mask << off;
  assign data_new   = {{XLEN{1'b0}}, req_wdata} << {off, 3'b000};
  assign split_new  = |mask_new[2*BW-1:BW];
  assign reject_new = illegal | (split_new & !ALLOW_MISALIGN);
  assign accept     = req_valid & (state_reg == IDLE);

  // State register; reset drops any in-flight transfer without a response.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Next-state decode; mem_ready only matters while a beat is presented.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (req_valid) state_next = reject_new ? RESP : BEAT0;
      BEAT0:   if (mem_ready) state_next = split_reg ? BEAT1 : RESP;
      BEAT1:   if (mem_ready) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Snapshot of both beats at acceptance so later req_* changes are ignored.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      addr_reg  <= '0;
      mask_reg  <= '0;
      data_reg  <= '0;
      split_reg <= 1'b0;
      err_reg   <= 1'b0;
    end else if (accept) begin
      addr_reg  <= {req_addr[XLEN-1:OW], {OW{1'b0}}};
      mask_reg  <= mask_new;
      data_reg  <= data_new;
      split_reg <= split_new;
      err_reg   <= reject_new;
    end
  end

  // Bus outputs are decoded from state; everything reads zero with no beat.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wmask = '0;
    case (state_reg)
      BEAT0: begin
        mem_addr  = addr_reg;
        mem_wdata = data_reg[XLEN-1:0];
        mem_wmask = mask_reg[BW-1:0];
      end
      BEAT1: begin
        mem_addr  = addr_reg + XLEN'(BW);
        mem_wdata = data_reg[2*XLEN-1:XLEN];
        mem_wmask = mask_reg[2*BW-1:BW];
      end
      default: ;
    endcase
  end

  assign req_ready = (state_reg == IDLE);
  assign mem_valid = (state_reg == BEAT0) || (state_reg == BEAT1);
  assign done      = (state_reg == RESP);
  assign err       = (state_reg == RESP) & err_reg;

endmodule

// File: doc/store_align_unit.md
STORE_ALIGN_UNIT -- requirements
Module: store_align_unit

Interface
REQ-001 SHALL have parameter XLEN, default 64, meaning data/address width in bits; BW = XLEN/8 bytes per beat, and OW = log2(BW).
REQ-002 SHALL have parameter ALLOW_MISALIGN, default 1, meaning a 1 splits bus-crossing stores into two beats and a 0 rejects them.
REQ-003 SHALL have ports, one per line:
- clk  in  1  sole clock, rising edge.
- rstn  in  1  asynchronous, active-low reset.
- req_valid  in  1  store request valid.
- req_ready  out  1  unit can accept a request.
- req_addr  in  XLEN  byte address.
- req_wdata  in  XLEN  store data, LSB-justified.
- req_width  in  3  width code: DW=001, W=010, HW=011, B=100, UW=101, UHW=110, UB=111.
- mem_valid  out  1  bus beat valid.
- mem_ready  in  1  bus accepts the beat.
- mem_addr  out  XLEN  BW-aligned beat address.
- mem_wdata  out  XLEN  byte-lane-positioned data.
- mem_wmask  out  BW  byte write enables.
- done  out  1  one-cycle completion pulse.
- err  out  1  qualifies done: the request was rejected.

Function
REQ-010 SHALL use the FSM states IDLE, BEAT0, BEAT1 and RESP, with every output registered or decoded from state only.
REQ-011 SHALL drive req_ready=1 only in IDLE; a request is accepted when req_valid and req_ready are both high at a clock edge.
REQ-012 SHALL derive the size from the width code: DW=8, W/UW=4, HW/UHW=2, B/UB=1 bytes; code 000 is illegal.
REQ-013 SHALL compute off = req_addr[OW-1:0], a 2*BW-bit mask m = ((1<<size)-1) << off, and 2*XLEN-bit data d = zero-extended req_wdata << (8*off).
REQ-014 SHALL form beat0 as addr = req_addr with the low OW bits cleared, mask = m[BW-1:0], data = d[XLEN-1:0].
REQ-015 SHALL form beat1 as addr = beat0 addr + BW (wrapping modulo 2^XLEN), mask = m[2BW-1:BW], data = d[2XLEN-1:XLEN].
REQ-016 SHALL treat a request as split when m[2BW-1:BW] is nonzero.
REQ-017 SHALL capture all beat fields at acceptance; later changes on the req_* inputs have no effect.
REQ-018 SHALL, on acceptance of a legal request that is unsplit, or split with ALLOW_MISALIGN=1, go IDLE->BEAT0 with mem_valid=1 in the next cycle.
REQ-019 SHALL, on acceptance of an illegal width, or of a split request with ALLOW_MISALIGN=0, go IDLE->RESP with err=1 and never assert mem_valid.
REQ-020 SHALL hold mem_valid, mem_addr, mem_wdata and mem_wmask stable in BEAT0/BEAT1 until mem_ready=1.
REQ-021 SHALL, in BEAT0 with mem_ready=1, go to BEAT1 if split, else to RESP.
REQ-022 SHALL, in BEAT1 with mem_ready=1, go to RESP.
REQ-023 SHALL drive mem_valid=1 only in BEAT0 and BEAT1.
REQ-024 SHALL, in RESP, assert done=1 for exactly one cycle, with err as captured and req_ready=0, then return to IDLE.
REQ-025 SHALL give a minimum latency of acceptance at edge N, beat0 at N+1, and done at N+2 when unsplit with mem_ready=1, or N+3 when split.
REQ-026 SHALL drive mem_wmask=0 and mem_wdata=0 whenever mem_valid=0.
REQ-027 SHALL ignore mem_ready outside BEAT0/BEAT1.

Reset
REQ-030 SHALL, while rstn=0, asynchronously force state=IDLE, mem_valid=0, done=0, err=0, mem_addr=0, mem_wdata=0 and mem_wmask=0.
REQ-031 SHALL drive req_ready=1 during and after reset.
REQ-032 SHALL discard an in-flight request when reset is asserted mid-transfer, including in BEAT1, with no done pulse.
REQ-033 SHALL make the first acceptance possible at the first rising edge with rstn=1.

Verification
REQ-040 SHALL cover: W store, addr 0x1004, data 0xDEADBEEF, mem_ready=1 -> one beat with addr 0x1000, mask 0xF0, data 0xDEADBEEF_00000000; done=1, err=0 at N+2.
REQ-041 SHALL cover: DW store, addr 0x1006, data 0x1122334455667788 -> beat0 addr 0x1000, mask 0xC0, data 0x7788000000000000; beat1 addr 0x1008, mask 0x3F, data 0x0000112233445566; done at N+3.
REQ-042 SHALL cover: the REQ-041 stimulus with ALLOW_MISALIGN=0 -> mem_valid stays 0; done=1, err=1 at N+1.
REQ-043 SHALL cover: B store, addr 0x2003, mem_ready low for 5 cycles -> mask 0x08 with the beat held constant for 6 cycles; exactly one done.
REQ-044 SHALL cover: rstn pulsed low during BEAT1 -> mem_valid=0 immediately; no done; req_ready=1 after release.
REQ-045 SHALL cover: req_width=000 -> no bus beat; done=1, err=1; req_ready=0 during RESP, then 1.
